// File: rtl/pipe_ctrl.sv
// Pipeline stage controller: per-stage register write enables and bubble/flush
// controls from the hazard inputs, plus saturating stall and flush counters.
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_load,
    input  logic        stall_I,
    input  logic        stall_D,
    input  logic        branch_taken,
    input  logic        perf_clr,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        bubble_id_ex,
    output logic        bubble_ex_mem,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LUSTALL  = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_e;

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic        flush_event;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: stall_D, branch, REDIRECT recovery, load-use, I-miss, advance.
    always_comb begin
        state_d       = state_q;
        flush_event   = 1'b0;
        load_pc       = 1'b0;
        load_if_id    = 1'b0;
        load_id_ex    = 1'b0;
        load_ex_mem   = 1'b0;
        load_mem_wb   = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;

        if (!reset_n) begin
            state_d = RUN;
        end else if (stall_D) begin
            state_d = state_q;
        end else if (branch_taken) begin
            load_pc       = 1'b1;
            load_if_id    = 1'b1;
            load_id_ex    = 1'b1;
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            flush_if_id   = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_ex_mem = 1'b1;
            flush_event   = 1'b1;
            state_d       = stall_I ? REDIRECT : RUN;
        end else if (state_q == REDIRECT) begin
            // The fetch in flight when the branch resolved is stale and is discarded.
            load_pc      = 1'b0;
            load_if_id   = !stall_I;
            flush_if_id  = !stall_I;
            bubble_id_ex = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            state_d      = stall_I ? REDIRECT : RUN;
        end else if (state_q == RUN && stall_load) begin
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            bubble_ex_mem = 1'b1;
            state_d       = LUSTALL;
        end else if (stall_I) begin
            bubble_id_ex = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            state_d      = RUN;
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            state_d     = RUN;
        end
    end

    // Counters saturate rather than wrap; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 16'h0000;
            flush_count  <= 16'h0000;
        end else if (perf_clr) begin
            stall_cycles <= 16'h0000;
            flush_count  <= 16'h0000;
        end else begin
            if (!load_pc && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'h0001;
            end
            if (flush_event && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'h0001;
            end
        end
    end

    assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Control vector order: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, bubble_id_ex, bubble_ex_mem}.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_load;
    logic        stall_I;
    logic        stall_D;
    logic        branch_taken;
    logic        perf_clr;
    logic        load_pc;
    logic        load_if_id;
    logic        load_id_ex;
    logic        load_ex_mem;
    logic        load_mem_wb;
    logic        flush_if_id;
    logic        bubble_id_ex;
    logic        bubble_ex_mem;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] ADV   = 8'hF8;
    localparam logic [7:0] BR    = 8'hFF;
    localparam logic [7:0] ISTL  = 8'h3A;
    localparam logic [7:0] RSUME = 8'h7E;
    localparam logic [7:0] LUSE  = 8'h19;
    localparam logic [7:0] NONE  = 8'h00;

    pipe_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_load   (stall_load),
        .stall_I      (stall_I),
        .stall_D      (stall_D),
        .branch_taken (branch_taken),
        .perf_clr     (perf_clr),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .flush_if_id  (flush_if_id),
        .bubble_id_ex (bubble_id_ex),
        .bubble_ex_mem(bubble_ex_mem),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, bubble_id_ex, bubble_ex_mem};

    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks follow 1 ns later and see the
    // state registered at the previous rising edge.
    task automatic drive(input logic sl, input logic si, input logic sd,
                         input logic bt, input logic pc);
        @(negedge clk);
        stall_load   = sl;
        stall_I      = si;
        stall_D      = sd;
        branch_taken = bt;
        perf_clr     = pc;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        stall_load = 1'b0; stall_I = 1'b0; stall_D = 1'b0;
        branch_taken = 1'b0; perf_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ctl !== NONE) begin errors++; $display("FAIL reset_ctl got=%h exp=%h", ctl, NONE); end
        checks++;
        if (ctrl_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", ctrl_state); end
        checks++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctl !== ADV) begin errors++; $display("FAIL first_advance got=%h exp=%h", ctl, ADV); end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || stall_cycles !== 16'd0) begin
            errors++; $display("FAIL post_reset got state=%0d stall=%0d exp=0/0", ctrl_state, stall_cycles);
        end
    endtask

    task automatic test_load_use;
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        checks++;
        if (ctl !== LUSE) begin errors++; $display("FAIL lu_cycle1 got=%h exp=%h", ctl, LUSE); end
        checks++;
        if (stall_cycles !== 16'd0) begin errors++; $display("FAIL lu_clear got=%0d exp=0", stall_cycles); end
        drive(1, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd1) begin errors++; $display("FAIL lu_state got=%0d exp=1", ctrl_state); end
        checks++;
        if (ctl !== ADV) begin errors++; $display("FAIL lu_cycle2 got=%h exp=%h", ctl, ADV); end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || stall_cycles !== 16'd1) begin
            errors++; $display("FAIL lu_end got state=%0d stall=%0d exp=0/1", ctrl_state, stall_cycles);
        end
    endtask

    task automatic test_branch_imiss;
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0);
        checks++;
        if (ctl !== BR) begin errors++; $display("FAIL br_cycle got=%h exp=%h", ctl, BR); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0);
            checks++;
            if (ctrl_state !== 2'd2 || ctl !== ISTL) begin
                errors++; $display("FAIL redirect_wait%0d got state=%0d ctl=%h exp=2/%h", i, ctrl_state, ctl, ISTL);
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd2 || ctl !== RSUME) begin
            errors++; $display("FAIL redirect_resume got state=%0d ctl=%h exp=2/%h", ctrl_state, ctl, RSUME);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || ctl !== ADV) begin
            errors++; $display("FAIL redirect_exit got state=%0d ctl=%h exp=0/%h", ctrl_state, ctl, ADV);
        end
        checks++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd4) begin
            errors++; $display("FAIL br_counters got flush=%0d stall=%0d exp=1/4", flush_count, stall_cycles);
        end
    endtask

    task automatic test_dstall_priority;
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 1, 0);
            checks++;
            if (ctl !== NONE || ctrl_state !== 2'd2) begin
                errors++; $display("FAIL dstall%0d got ctl=%h state=%0d exp=%h/2", i, ctl, ctrl_state, NONE);
            end
            checks++;
            if (flush_count !== 16'd1 || stall_cycles !== 16'(i)) begin
                errors++; $display("FAIL dstall_cnt%0d got flush=%0d stall=%0d exp=1/%0d", i, flush_count, stall_cycles, i);
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd2 || ctl !== RSUME) begin
            errors++; $display("FAIL dstall_hold got state=%0d ctl=%h exp=2/%h", ctrl_state, ctl, RSUME);
        end
        checks++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd4) begin
            errors++; $display("FAIL dstall_counters got flush=%0d stall=%0d exp=1/4", flush_count, stall_cycles);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || stall_cycles !== 16'd5) begin
            errors++; $display("FAIL dstall_end got state=%0d stall=%0d exp=0/5", ctrl_state, stall_cycles);
        end
    endtask

    task automatic test_back_to_back;
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        checks++;
        if (ctrl_state !== 2'd2 || ctl !== BR) begin
            errors++; $display("FAIL b2b_branch got state=%0d ctl=%h exp=2/%h", ctrl_state, ctl, BR);
        end
        drive(1, 1, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || ctl !== LUSE) begin
            errors++; $display("FAIL b2b_loaduse got state=%0d ctl=%h exp=0/%h", ctrl_state, ctl, LUSE);
        end
        drive(1, 1, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd1 || ctl !== ISTL) begin
            errors++; $display("FAIL b2b_lustall_imiss got state=%0d ctl=%h exp=1/%h", ctrl_state, ctl, ISTL);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || ctl !== ADV) begin
            errors++; $display("FAIL b2b_end got state=%0d ctl=%h exp=0/%h", ctrl_state, ctl, ADV);
        end
        checks++;
        if (flush_count !== 16'd2 || stall_cycles !== 16'd2) begin
            errors++; $display("FAIL b2b_counters got flush=%0d stall=%0d exp=2/2", flush_count, stall_cycles);
        end
    endtask

    task automatic test_saturation;
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0);
        repeat (65540) @(negedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++; $display("FAIL sat_value got=%h exp=ffff", stall_cycles);
        end
        drive(0, 0, 1, 0, 1);
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles);
        end
        drive(0, 0, 1, 0, 0);
        checks++;
        if (stall_cycles !== 16'h0000) begin
            errors++; $display("FAIL sat_clear got=%h exp=0000", stall_cycles);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (stall_cycles !== 16'h0001) begin
            errors++; $display("FAIL sat_restart got=%h exp=0001", stall_cycles);
        end
    endtask

    task automatic test_async_reset;
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd2 || ctl !== ISTL) begin
            errors++; $display("FAIL ar_setup got state=%0d ctl=%h exp=2/%h", ctrl_state, ctl, ISTL);
        end
        #1;
        reset_n = 1'b0;
        stall_I = 1'b0;
        #1;
        checks++;
        if (ctl !== NONE || ctrl_state !== 2'd0) begin
            errors++; $display("FAIL ar_immediate got ctl=%h state=%0d exp=%h/0", ctl, ctrl_state, NONE);
        end
        checks++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            errors++; $display("FAIL ar_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (ctrl_state !== 2'd0 || ctl !== ADV) begin
            errors++; $display("FAIL ar_release got state=%0d ctl=%h exp=0/%h", ctrl_state, ctl, ADV);
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (flush_if_id !== 1'b0 || ctrl_state !== 2'd0) begin
            errors++; $display("FAIL ar_no_flush got flush=%b state=%0d exp=0/0", flush_if_id, ctrl_state);
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_branch_imiss;
        test_dstall_priority;
        test_back_to_back;
        test_saturation;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port stall_load, input, 1: load-use hazard request from the hazard unit.
REQ-004 SHALL have port stall_I, input, 1: instruction memory not ready this cycle.
REQ-005 SHALL have port stall_D, input, 1: data memory busy; MEM stage cannot complete.
REQ-006 SHALL have port branch_taken, input, 1: taken branch/jump resolved in MEM; PC mux selects target.
REQ-007 SHALL have port perf_clr, input, 1: synchronous clear of performance counters.
REQ-008 SHALL have ports load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, each output, 1: register write enables.
REQ-009 SHALL have ports flush_if_id, bubble_id_ex, bubble_ex_mem, each output, 1: when high, the loaded register takes a NOP (valid=0) instead of upstream contents.
REQ-010 SHALL have port ctrl_state, output, 2: current FSM state, encoded RUN=0, LUSTALL=1, REDIRECT=2.
REQ-011 SHALL have ports stall_cycles and flush_count, each output, 16: saturating performance counters.

Function
REQ-012 SHALL hold a registered 2-bit state (RUN, LUSTALL, REDIRECT); all enable/bubble outputs are combinational from state and inputs.
REQ-013 SHALL resolve cycle actions in priority order: stall_D > branch_taken > REDIRECT handling > stall_load > stall_I > normal advance.
REQ-014 SHALL, with stall_D=1 in any state: drive all load_* = 0 and all flush/bubble = 0; hold state; ignore branch_taken and stall_load.
REQ-015 SHALL, with branch_taken=1 (stall_D=0) in RUN or LUSTALL: drive all load_* = 1 and flush_if_id = bubble_id_ex = bubble_ex_mem = 1; next state REDIRECT if stall_I=1, else RUN.
REQ-016 SHALL, in REDIRECT with stall_I=1 and branch_taken=0: drive load_pc = load_if_id = 0 and bubble_id_ex = 1, with the other loads = 1; remain in REDIRECT.
REQ-017 SHALL, in REDIRECT with stall_I=0 and branch_taken=0: drive load_pc = 0, load_if_id = 1, flush_if_id = 1 (discard the stale fetch), and bubble_id_ex = 1, with the other loads = 1; next state RUN.
REQ-018 SHALL, in REDIRECT with branch_taken=1: apply REQ-015 and remain in REDIRECT if stall_I=1.
REQ-019 SHALL, in RUN with stall_load=1 (no higher-priority event): drive load_pc = load_if_id = load_id_ex = 0 and load_ex_mem = load_mem_wb = bubble_ex_mem = 1; next state LUSTALL.
REQ-020 SHALL, in LUSTALL: ignore stall_load; apply the stall_I rule (REQ-021) or normal advance; next state RUN.
REQ-021 SHALL, in RUN/LUSTALL with stall_I=1 (no higher-priority event): drive load_pc = load_if_id = 0 and bubble_id_ex = 1, with the other loads = 1.
REQ-022 SHALL, on normal advance, drive all load_* = 1 and all flush/bubble = 0.
REQ-023 SHALL increment stall_cycles on every out-of-reset cycle with load_pc=0; SHALL increment flush_count on every cycle applying REQ-015.
REQ-024 SHALL saturate both counters at 16'hFFFF (no wrap).
REQ-025 SHALL, with perf_clr=1, load both counters with 0 on the next edge; clear wins over a same-cycle increment.

Reset
REQ-026 SHALL, while reset_n=0, force state=RUN and counters=0 asynchronously, and drive all load_*/flush/bubble outputs to 0.
REQ-027 SHALL, on the first edge after reset_n rises with no stall inputs, produce normal advance (all load_* = 1).
REQ-028 SHALL, on reset asserted mid-stall or mid-REDIRECT, abandon the pending discard; no flush_if_id after release.

Verification
REQ-029 SHALL cover load-use: RUN, stall_load=1 for 2 cycles -> cycle 1 loads PC/IF/ID/EX = 0 with bubble_ex_mem=1; cycle 2 normal advance; stall_cycles=1.
REQ-030 SHALL cover branch during an I-miss: branch_taken=1 with stall_I=1, stall_I held 3 more cycles then 0 -> REDIRECT for 3 cycles with load_pc=0, then one cycle of flush_if_id=1, then RUN; flush_count=1.
REQ-031 SHALL cover D-stall priority: stall_D=1 with branch_taken=1 and stall_load=1 for 4 cycles -> all load_* = 0, state unchanged, flush_count unchanged, stall_cycles +4.
REQ-032 SHALL cover saturation: force 70000 stall cycles -> stall_cycles=16'hFFFF; then perf_clr=1 -> 0 on the next edge.
REQ-033 SHALL cover async reset mid-REDIRECT: reset_n low between edges -> outputs 0 immediately; after release, ctrl_state=0 and no flush_if_id.
